// File: rtl/if_prefetch_pkg.sv
// Shared constants and helpers for the instruction-fetch prefetch stage.
package if_prefetch_pkg;

   localparam int unsigned INSTR_WIDTH = 32;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_NONSEQ = 2'b10
   } htrans_e;

   localparam logic [2:0]             HSIZE_WORD    = 3'b010;
   localparam logic [2:0]             HBURST_SINGLE = 3'b000;
   localparam logic [3:0]             HPROT_NONE    = 4'b0000;
   localparam logic [INSTR_WIDTH-1:0] INSTR_NOP     = 32'h0000_0013;

   // Instruction word stored for a completed fetch; faulted fetches become a NOP.
   function automatic logic [INSTR_WIDTH-1:0] fetch_instr(input logic fault,
                                                          input logic [INSTR_WIDTH-1:0] rdata);
      return fault ? INSTR_NOP : rdata;
   endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous first-word-fall-through FIFO holding prefetched instructions.
module if_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy tracking; pointers wrap naturally at a power-of-two depth.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (!do_push && do_pop) count <= count - CW'(1);
      end
   end

   // Entry storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage: AHB-Lite instruction master feeding a prefetch FIFO toward ID.
module if_prefetch
   import if_prefetch_pkg::*;
#(
   parameter int unsigned          PC_WIDTH   = 32,
   parameter int unsigned          ADDR_WIDTH = 16,
   parameter int unsigned          FIFO_DEPTH = 4,
   parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic [1:0]              ibus_htrans,
   output logic [ADDR_WIDTH-1:0]   ibus_haddr,
   output logic                    ibus_hwrite,
   output logic [2:0]              ibus_hsize,
   output logic [2:0]              ibus_hburst,
   output logic [3:0]              ibus_hport,
   output logic                    ibus_hmastlock,
   output logic [31:0]             ibus_hwdata,
   input  logic                    ibus_hready,
   input  logic                    ibus_hresp,
   input  logic [31:0]             ibus_hrdata,
   input  logic                    take_branch,
   input  logic                    if_flush,
   input  logic [PC_WIDTH-1:0]     target_pc,
   input  logic                    if2id_stall,
   output logic                    if2id_valid,
   output logic [PC_WIDTH-1:0]     if2id_pc,
   output logic [31:0]             if2id_instruction,
   output logic                    if2id_fault
);

   localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned CRED_W  = CNT_W + 1;
   localparam int unsigned ENTRY_W = 1 + PC_WIDTH + INSTR_WIDTH;

   logic [PC_WIDTH-1:0] fetch_pc,    fetch_pc_nxt;
   logic [PC_WIDTH-1:0] data_pc,     data_pc_nxt;
   logic [PC_WIDTH-1:0] redirect_pc, redirect_pc_nxt;
   logic                inflight,    inflight_nxt;
   logic                stale,       stale_nxt;
   logic                halted,      halted_nxt;
   logic                redir_pend,  redir_pend_nxt;
   logic                addr_held,   addr_held_nxt;

   logic                redirect;
   logic                credit_ok;
   logic                data_done;
   logic                data_err;
   logic                issue_ok;
   logic                nonseq;
   logic                accept;
   logic                push;
   logic                pop;

   logic [CNT_W-1:0]    count;
   logic                full;
   logic                empty;
   logic [ENTRY_W-1:0]  push_entry;
   logic [ENTRY_W-1:0]  head_entry;

   // Fixed attributes: single-beat word reads only.
   assign ibus_hwrite    = 1'b0;
   assign ibus_hsize     = HSIZE_WORD;
   assign ibus_hburst    = HBURST_SINGLE;
   assign ibus_hport     = HPROT_NONE;
   assign ibus_hmastlock = 1'b0;
   assign ibus_hwdata    = '0;

   assign ibus_haddr  = fetch_pc[ADDR_WIDTH-1:0];
   assign ibus_htrans = nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;

   if (PC_WIDTH > ADDR_WIDTH) begin : g_pc_hi
      logic unused_pc_hi;
      assign unused_pc_hi = ^fetch_pc[PC_WIDTH-1:ADDR_WIDTH];
   end

   // Bus-side control: issue credit, held transfers, push/pop qualification.
   always_comb begin
      redirect  = take_branch | if_flush;
      credit_ok = (CRED_W'(count) + CRED_W'(inflight)) < CRED_W'(FIFO_DEPTH);
      data_done = inflight & ibus_hready;
      // An error completing now blocks the address phase that would otherwise follow it.
      data_err  = data_done & ~stale & ibus_hresp;
      issue_ok  = credit_ok & ~halted & ~redirect & ~redir_pend & ~data_err;
      // A transfer waited by hready low must be presented again unchanged.
      nonseq    = ~rst & (addr_held | issue_ok);
      accept    = nonseq & ibus_hready;
      push      = data_done & ~stale & ~redirect & ~redir_pend;
      pop       = if2id_valid & ~if2id_stall & ~redirect;
   end

   // Next-state for fetch address, in-flight tracking, halt and deferred redirect.
   always_comb begin
      fetch_pc_nxt    = fetch_pc;
      data_pc_nxt     = data_pc;
      redirect_pc_nxt = redirect_pc;
      inflight_nxt    = inflight;
      stale_nxt       = stale;
      halted_nxt      = halted;
      redir_pend_nxt  = redir_pend;
      addr_held_nxt   = nonseq & ~ibus_hready;

      if (accept) data_pc_nxt = fetch_pc;

      if (ibus_hready) begin
         inflight_nxt   = accept;
         // Anything accepted alongside a redirect or an error is dropped when it returns.
         stale_nxt      = accept & (redirect | redir_pend | data_err);
         redir_pend_nxt = 1'b0;
         if (redirect || redir_pend) begin
            fetch_pc_nxt = redirect ? target_pc : redirect_pc;
            halted_nxt   = 1'b0;
         end else begin
            if (accept)   fetch_pc_nxt = fetch_pc + PC_WIDTH'(4);
            if (data_err) halted_nxt   = 1'b1;
         end
      end else if (redirect) begin
         redir_pend_nxt  = 1'b1;
         redirect_pc_nxt = target_pc;
         stale_nxt       = stale | inflight;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         data_pc     <= '0;
         redirect_pc <= '0;
         inflight    <= 1'b0;
         stale       <= 1'b0;
         halted      <= 1'b0;
         redir_pend  <= 1'b0;
         addr_held   <= 1'b0;
      end else begin
         fetch_pc    <= fetch_pc_nxt;
         data_pc     <= data_pc_nxt;
         redirect_pc <= redirect_pc_nxt;
         inflight    <= inflight_nxt;
         stale       <= stale_nxt;
         halted      <= halted_nxt;
         redir_pend  <= redir_pend_nxt;
         addr_held   <= addr_held_nxt;
      end
   end

   assign push_entry = {ibus_hresp, data_pc, fetch_instr(ibus_hresp, ibus_hrdata)};

   if_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (redirect),
      .push  (push),
      .pop   (pop),
      .din   (push_entry),
      .dout  (head_entry),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Head entry presented to ID; fault is only meaningful with a valid head.
   assign if2id_valid       = ~empty;
   assign if2id_fault       = ~empty & head_entry[ENTRY_W-1];
   assign if2id_pc          = head_entry[ENTRY_W-2 -: PC_WIDTH];
   assign if2id_instruction = head_entry[INSTR_WIDTH-1:0];

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch with a zero-wait AHB instruction RAM model.
module tb_if_prefetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  ibus_htrans;
   logic [15:0] ibus_haddr;
   logic        ibus_hwrite;
   logic [2:0]  ibus_hsize;
   logic [2:0]  ibus_hburst;
   logic [3:0]  ibus_hport;
   logic        ibus_hmastlock;
   logic [31:0] ibus_hwdata;
   logic        ibus_hready;
   logic        ibus_hresp;
   logic [31:0] ibus_hrdata;
   logic        take_branch;
   logic        if_flush;
   logic [31:0] target_pc;
   logic        if2id_stall;
   logic        if2id_valid;
   logic [31:0] if2id_pc;
   logic [31:0] if2id_instruction;
   logic        if2id_fault;

   int total = 0;
   int bad   = 0;

   // RAM model state: data phase tracking and error injection.
   logic        dp_valid;
   logic [15:0] dp_addr;
   logic        err_armed;
   logic [15:0] err_addr;

   always #5 clk = ~clk;

   if_prefetch dut (
      .clk               (clk),
      .rst               (rst),
      .ibus_htrans       (ibus_htrans),
      .ibus_haddr        (ibus_haddr),
      .ibus_hwrite       (ibus_hwrite),
      .ibus_hsize        (ibus_hsize),
      .ibus_hburst       (ibus_hburst),
      .ibus_hport        (ibus_hport),
      .ibus_hmastlock    (ibus_hmastlock),
      .ibus_hwdata       (ibus_hwdata),
      .ibus_hready       (ibus_hready),
      .ibus_hresp        (ibus_hresp),
      .ibus_hrdata       (ibus_hrdata),
      .take_branch       (take_branch),
      .if_flush          (if_flush),
      .target_pc         (target_pc),
      .if2id_stall       (if2id_stall),
      .if2id_valid       (if2id_valid),
      .if2id_pc          (if2id_pc),
      .if2id_instruction (if2id_instruction),
      .if2id_fault       (if2id_fault)
   );

   // Slave: capture accepted address phases; data word is 0xC0DE concatenated with the address.
   always @(posedge clk) begin
      if (rst) begin
         dp_valid <= 1'b0;
      end else if (ibus_hready) begin
         dp_valid <= (ibus_htrans == 2'b10);
         dp_addr  <= ibus_haddr;
      end
   end

   assign ibus_hrdata = dp_valid ? {16'hC0DE, dp_addr} : 32'h0;
   assign ibus_hresp  = err_armed & dp_valid & (dp_addr == err_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Bus check: htrans, plus haddr when a NONSEQ is expected.
   task automatic chk_bus(input string tag, input logic nonseq, input logic [15:0] addr);
      chk({tag, ".htrans"}, 32'(ibus_htrans), nonseq ? 32'h2 : 32'h0);
      if (nonseq) chk({tag, ".haddr"}, 32'(ibus_haddr), 32'(addr));
   endtask

   // ID-side check: valid, and pc/instruction/fault when valid is expected.
   task automatic chk_out(input string tag, input logic valid, input logic [31:0] pc,
                          input logic fault);
      logic [31:0] exp_instr;
      exp_instr = fault ? 32'h0000_0013 : {16'hC0DE, pc[15:0]};
      chk({tag, ".valid"}, 32'(if2id_valid), 32'(valid));
      if (valid) begin
         chk({tag, ".pc"},    if2id_pc, pc);
         chk({tag, ".instr"}, if2id_instruction, exp_instr);
         chk({tag, ".fault"}, 32'(if2id_fault), 32'(fault));
      end
   endtask

   // Reset for two cycles from wherever the run is; returns at the first post-reset cycle.
   task automatic do_reset();
      @(negedge clk);
      rst         = 1'b1;
      take_branch = 1'b0;
      if_flush    = 1'b0;
      if2id_stall = 1'b0;
      ibus_hready = 1'b1;
      err_armed   = 1'b0;
      #1 chk_bus("rst_htrans", 1'b0, 16'h0);
      @(negedge clk);
      #1 chk_out("rst_valid", 1'b0, 32'h0, 1'b0);
      chk("rst_fault", 32'(if2id_fault), 32'h0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   initial begin
      rst         = 1'b1;
      ibus_hready = 1'b1;
      take_branch = 1'b0;
      if_flush    = 1'b0;
      target_pc   = 32'h0;
      if2id_stall = 1'b0;
      err_armed   = 1'b0;
      err_addr    = 16'h0;

      // Reset state and constant bus attributes.
      repeat (3) @(negedge clk);
      #1;
      chk_bus("reset", 1'b0, 16'h0);
      chk_out("reset", 1'b0, 32'h0, 1'b0);
      chk("reset.fault", 32'(if2id_fault), 32'h0);
      chk("hsize",     32'(ibus_hsize),     32'h2);
      chk("hwrite",    32'(ibus_hwrite),    32'h0);
      chk("hburst",    32'(ibus_hburst),    32'h0);
      chk("hport",     32'(ibus_hport),     32'h0);
      chk("hmastlock", 32'(ibus_hmastlock), 32'h0);
      chk("hwdata",    ibus_hwdata,         32'h0);

      // Streaming with zero-wait RAM: one fetch per cycle, valid two cycles after release.
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_bus("stream0", 1'b1, 16'h0);
      chk_out("stream0", 1'b0, 32'h0, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         next_cycle(); #1;
         chk_bus("stream", 1'b1, 16'(4 * k));
         if (k >= 2) chk_out("stream", 1'b1, 32'(4 * (k - 2)), 1'b0);
         else        chk_out("stream", 1'b0, 32'h0, 1'b0);
      end

      // Stall: exactly four entries buffered, bus idles, then drains in order.
      do_reset();
      if2id_stall = 1'b1;
      #1 chk_bus("stall0", 1'b1, 16'h0);
      for (int k = 1; k <= 3; k++) begin
         next_cycle(); #1;
         chk_bus("stall_fill", 1'b1, 16'(4 * k));
      end
      for (int k = 4; k <= 9; k++) begin
         next_cycle(); #1;
         chk_bus("stall_full", 1'b0, 16'h0);
         chk_out("stall_full", 1'b1, 32'h0, 1'b0);
      end
      next_cycle();
      if2id_stall = 1'b0;
      #1 chk_bus("drain0", 1'b0, 16'h0);
      chk_out("drain0", 1'b1, 32'h0, 1'b0);
      next_cycle(); #1 chk_out("drain1", 1'b1, 32'h4, 1'b0);
      chk_bus("drain1", 1'b1, 16'h10);
      next_cycle(); #1 chk_out("drain2", 1'b1, 32'h8, 1'b0);
      chk_bus("drain2", 1'b1, 16'h14);
      next_cycle(); #1 chk_out("drain3", 1'b1, 32'hC, 1'b0);
      next_cycle(); #1 chk_out("drain4", 1'b1, 32'h10, 1'b0);
      next_cycle(); #1 chk_out("drain5", 1'b1, 32'h14, 1'b0);

      // Three wait states on the address phase of 0x4.
      do_reset();
      #1 chk_bus("wait0", 1'b1, 16'h0);
      next_cycle();
      ibus_hready = 1'b0;
      #1 chk_bus("wait1", 1'b1, 16'h4);
      chk_out("wait1", 1'b0, 32'h0, 1'b0);
      next_cycle(); #1 chk_bus("wait2", 1'b1, 16'h4);
      chk_out("wait2", 1'b0, 32'h0, 1'b0);
      next_cycle(); #1 chk_bus("wait3", 1'b1, 16'h4);
      chk_out("wait3", 1'b0, 32'h0, 1'b0);
      next_cycle();
      ibus_hready = 1'b1;
      #1 chk_bus("wait4", 1'b1, 16'h4);
      chk_out("wait4", 1'b0, 32'h0, 1'b0);
      next_cycle(); #1 chk_out("wait5", 1'b1, 32'h0, 1'b0);
      chk_bus("wait5", 1'b1, 16'h8);
      next_cycle(); #1 chk_out("wait6", 1'b1, 32'h4, 1'b0);
      next_cycle(); #1 chk_out("wait7", 1'b1, 32'h8, 1'b0);

      // Branch to 0x100 while the data phase of 0x8 completes.
      do_reset();
      next_cycle();
      next_cycle(); #1 chk_out("br2", 1'b1, 32'h0, 1'b0);
      next_cycle();
      take_branch = 1'b1;
      target_pc   = 32'h100;
      #1 chk_bus("br3", 1'b0, 16'h0);
      chk_out("br3", 1'b1, 32'h4, 1'b0);
      next_cycle();
      take_branch = 1'b0;
      #1 chk_bus("br4", 1'b1, 16'h100);
      chk_out("br4", 1'b0, 32'h0, 1'b0);
      next_cycle(); #1 chk_out("br5", 1'b0, 32'h0, 1'b0);
      chk_bus("br5", 1'b1, 16'h104);
      next_cycle(); #1 chk_out("br6", 1'b1, 32'h100, 1'b0);
      next_cycle(); #1 chk_out("br7", 1'b1, 32'h104, 1'b0);

      // Redirect to 0x200 while NONSEQ 0x10 waits two cycles.
      do_reset();
      repeat (3) next_cycle();
      next_cycle();
      ibus_hready = 1'b0;
      #1 chk_bus("rw4", 1'b1, 16'h10);
      chk_out("rw4", 1'b1, 32'h8, 1'b0);
      next_cycle();
      take_branch = 1'b1;
      target_pc   = 32'h200;
      #1 chk_bus("rw5", 1'b1, 16'h10);
      chk_out("rw5", 1'b0, 32'h0, 1'b0);
      next_cycle();
      take_branch = 1'b0;
      ibus_hready = 1'b1;
      #1 chk_bus("rw6", 1'b1, 16'h10);
      chk_out("rw6", 1'b0, 32'h0, 1'b0);
      next_cycle(); #1 chk_bus("rw7", 1'b1, 16'h200);
      chk_out("rw7", 1'b0, 32'h0, 1'b0);
      next_cycle(); #1 chk_out("rw8", 1'b0, 32'h0, 1'b0);
      chk_bus("rw8", 1'b1, 16'h204);
      next_cycle(); #1 chk_out("rw9", 1'b1, 32'h200, 1'b0);
      next_cycle(); #1 chk_out("rw10", 1'b1, 32'h204, 1'b0);

      // Bus error at 0x14 halts fetching until a branch; then a flush to 0x80.
      do_reset();
      err_armed = 1'b1;
      err_addr  = 16'h14;
      repeat (4) next_cycle();
      next_cycle(); #1 chk_bus("err5", 1'b1, 16'h14);
      chk_out("err5", 1'b1, 32'hC, 1'b0);
      next_cycle(); #1 chk_bus("err6", 1'b0, 16'h0);
      chk_out("err6", 1'b1, 32'h10, 1'b0);
      next_cycle(); #1 chk_bus("err7", 1'b0, 16'h0);
      chk_out("err7", 1'b1, 32'h14, 1'b1);
      next_cycle(); #1 chk_bus("err8", 1'b0, 16'h0);
      chk_out("err8", 1'b0, 32'h0, 1'b0);
      next_cycle(); #1 chk_bus("err9", 1'b0, 16'h0);
      next_cycle();
      take_branch = 1'b1;
      target_pc   = 32'h40;
      err_armed   = 1'b0;
      #1 chk_bus("err10", 1'b0, 16'h0);
      next_cycle();
      take_branch = 1'b0;
      #1 chk_bus("err11", 1'b1, 16'h40);
      next_cycle(); #1 chk_bus("err12", 1'b1, 16'h44);
      chk_out("err12", 1'b0, 32'h0, 1'b0);
      next_cycle(); #1 chk_out("err13", 1'b1, 32'h40, 1'b0);
      next_cycle();
      if_flush  = 1'b1;
      target_pc = 32'h80;
      #1 chk_bus("fl14", 1'b0, 16'h0);
      chk_out("fl14", 1'b1, 32'h44, 1'b0);
      next_cycle();
      if_flush = 1'b0;
      #1 chk_bus("fl15", 1'b1, 16'h80);
      chk_out("fl15", 1'b0, 32'h0, 1'b0);
      next_cycle(); #1 chk_out("fl16", 1'b0, 32'h0, 1'b0);
      next_cycle(); #1 chk_out("fl17", 1'b1, 32'h80, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
